// File: rtl/sync_fifo_buf_if.sv
// sync_fifo_buf_if: producer/consumer handshake and status bundle for sync_fifo_buf.
//   master : drives flush, clr_err, wr_en, wdata, rd_en; observes read data and status
//   slave  : the FIFO side; drives rdata, rvalid, count, full/empty, thresholds, error flags
interface sync_fifo_buf_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4
);
    logic                  flush;
    logic                  clr_err;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  rvalid;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [ADDR_WIDTH:0]   count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output flush, clr_err, wr_en, wdata, rd_en,
        input  rdata, rvalid, full, empty, almost_full, almost_empty, count, overflow, underflow
    );

    modport slave (
        input  flush, clr_err, wr_en, wdata, rd_en,
        output rdata, rvalid, full, empty, almost_full, almost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_buf.sv
// sync_fifo_buf: single-clock FIFO with registered read port, occupancy count,
// almost-full/almost-empty thresholds, synchronous flush and sticky error flags.
//   clk_i : clock, all state on the rising edge
//   rst_i : synchronous active-high reset
//   bus   : slave side of sync_fifo_buf_if (requests in, data/status out)
// Every output is a register; status flags are decoded from the next count value
// so they always agree with the registered count.
module sync_fifo_buf #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned AFULL_THR  = 14,
    parameter int unsigned AEMPTY_THR = 2
) (
    input  logic           clk_i,
    input  logic           rst_i,
    sync_fifo_buf_if.slave bus
);
    localparam int unsigned PTR_W = ADDR_WIDTH + 1;

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

    logic [PTR_W-1:0]      wptr_q, wptr_d;
    logic [PTR_W-1:0]      rptr_q, rptr_d;
    logic [PTR_W-1:0]      count_q, count_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  rvalid_q, rvalid_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic                  afull_q, afull_d;
    logic                  aempty_q, aempty_d;
    logic                  ovf_q, ovf_d;
    logic                  udf_q, udf_d;

    logic wr_ok, rd_ok, ovf_set, udf_set;

    // Request qualification against the current registered flags; flush blocks both.
    always_comb begin
        wr_ok   = bus.wr_en && !full_q  && !bus.flush;
        rd_ok   = bus.rd_en && !empty_q && !bus.flush;
        ovf_set = bus.wr_en &&  full_q  && !bus.flush;
        udf_set = bus.rd_en &&  empty_q && !bus.flush;
    end

    // Next-state for pointers, count, read port, status and error flags.
    always_comb begin
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        count_d  = count_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;

        if (bus.flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (wr_ok) begin
                wptr_d = wptr_q + PTR_W'(1);
            end
            if (rd_ok) begin
                rptr_d   = rptr_q + PTR_W'(1);
                rdata_d  = mem_q[rptr_q[ADDR_WIDTH-1:0]];
                rvalid_d = 1'b1;
            end
            // Simultaneous accepted read and write leaves occupancy unchanged.
            case ({wr_ok, rd_ok})
                2'b10:   count_d = count_q + PTR_W'(1);
                2'b01:   count_d = count_q - PTR_W'(1);
                default: count_d = count_q;
            endcase
        end

        full_d   = (count_d == PTR_W'(FIFO_DEPTH));
        empty_d  = (count_d == '0);
        afull_d  = (count_d >= PTR_W'(AFULL_THR));
        aempty_d = (count_d <= PTR_W'(AEMPTY_THR));

        // A new error in the same cycle as clr_err keeps the flag set.
        ovf_d = ovf_set ? 1'b1 : (bus.clr_err ? 1'b0 : ovf_q);
        udf_d = udf_set ? 1'b1 : (bus.clr_err ? 1'b0 : udf_q);
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= (AFULL_THR == 0);
            aempty_q <= 1'b1;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            count_q  <= count_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            afull_q  <= afull_d;
            aempty_q <= aempty_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // Storage array; contents are intentionally not reset.
    always_ff @(posedge clk_i) begin
        if (wr_ok && !rst_i) begin
            mem_q[wptr_q[ADDR_WIDTH-1:0]] <= bus.wdata;
        end
    end

    assign bus.rdata        = rdata_q;
    assign bus.rvalid       = rvalid_q;
    assign bus.count        = count_q;
    assign bus.full         = full_q;
    assign bus.empty        = empty_q;
    assign bus.almost_full  = afull_q;
    assign bus.almost_empty = aempty_q;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = udf_q;
endmodule

// File: tb/tb_sync_fifo_buf.sv
// tb_sync_fifo_buf: directed stimulus for sync_fifo_buf with a queue-based reference
// model, a per-cycle compare process and literal spot checks.
module tb_sync_fifo_buf;
    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned AW    = 4;
    localparam int unsigned AFT   = 14;
    localparam int unsigned AET   = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sync_fifo_buf_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    sync_fifo_buf #(
        .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .ADDR_WIDTH(AW),
        .AFULL_THR(AFT), .AEMPTY_THR(AET)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: contents as a queue, outputs as plain variables.
    logic [DW-1:0] q[$];
    logic [DW-1:0] m_rdata  = '0;
    logic          m_rvalid = 1'b0;
    logic          m_ovf    = 1'b0;
    logic          m_udf    = 1'b0;
    bit            m_live   = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            m_rdata  = '0;
            m_rvalid = 1'b0;
            m_ovf    = 1'b0;
            m_udf    = 1'b0;
            m_live   = 1'b1;
        end else begin
            int  n;
            bit  was_full, was_empty, ovf_new, udf_new;
            n         = q.size();
            was_full  = (n == DEPTH);
            was_empty = (n == 0);
            ovf_new   = 1'b0;
            udf_new   = 1'b0;
            m_rvalid  = 1'b0;
            if (bus.flush) begin
                q.delete();
            end else begin
                if (bus.rd_en) begin
                    if (was_empty) udf_new = 1'b1;
                    else begin
                        m_rdata  = q.pop_front();
                        m_rvalid = 1'b1;
                    end
                end
                if (bus.wr_en) begin
                    if (was_full) ovf_new = 1'b1;
                    else q.push_back(bus.wdata);
                end
            end
            if (ovf_new) m_ovf = 1'b1; else if (bus.clr_err) m_ovf = 1'b0;
            if (udf_new) m_udf = 1'b1; else if (bus.clr_err) m_udf = 1'b0;
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (m_live) begin
            int   n;
            logic [DW+AW+8:0] exp_v, act_v;
            n = q.size();
            exp_v = {m_rdata, m_rvalid, 5'(n), n == DEPTH, n == 0, n >= AFT, n <= AET, m_ovf, m_udf};
            act_v = {bus.rdata, bus.rvalid, bus.count, bus.full, bus.empty,
                     bus.almost_full, bus.almost_empty, bus.overflow, bus.underflow};
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL cycle_compare t=%0t got {rdata,rvalid,count,full,empty,af,ae,ovf,udf}=%h expected %h",
                         $time, act_v, exp_v);
            end
        end
    end

    task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    // Apply one cycle of inputs; returns at the following negedge.
    task automatic cyc(input bit w, input logic [DW-1:0] d, input bit r,
                       input bit fl = 1'b0, input bit ce = 1'b0, input bit rs = 1'b0);
        rst         = rs;
        bus.wr_en   = w;
        bus.wdata   = d;
        bus.rd_en   = r;
        bus.flush   = fl;
        bus.clr_err = ce;
        @(negedge clk);
    endtask

    task automatic idle();
        cyc(1'b0, '0, 1'b0);
    endtask

    initial begin
        bus.wr_en = 1'b0; bus.wdata = '0; bus.rd_en = 1'b0;
        bus.flush = 1'b0; bus.clr_err = 1'b0;
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle();
        lit("reset_count", 32'(bus.count), 0);
        lit("reset_flags", {26'd0, bus.empty, bus.full, bus.almost_empty, bus.almost_full,
                            bus.overflow, bus.underflow}, 32'b101000);
        lit("reset_rdata", {23'd0, bus.rvalid, bus.rdata}, 0);

        // Fill with 0x01..0x10.
        for (int i = 1; i <= 16; i++) begin
            cyc(1'b1, 8'(i), 1'b0);
            if (i == 13) lit("afull_at_13", 32'(bus.almost_full), 0);
            if (i == 14) lit("afull_at_14", 32'(bus.almost_full), 1);
        end
        lit("full_count", {26'd0, bus.full, bus.count}, {26'd0, 1'b1, 5'd16});
        cyc(1'b1, 8'hAA, 1'b0);
        lit("overflow_set", {26'd0, bus.overflow, bus.count}, {26'd0, 1'b1, 5'd16});

        // Drain in order.
        for (int i = 1; i <= 16; i++) begin
            cyc(1'b0, '0, 1'b1);
            lit("drain_word", {23'd0, bus.rvalid, bus.rdata}, {23'd0, 1'b1, 8'(i)});
        end
        lit("drained_empty", 32'(bus.empty), 1);
        cyc(1'b0, '0, 1'b1);
        lit("underflow_hold", {22'd0, bus.underflow, bus.rvalid, bus.rdata}, {22'd0, 2'b10, 8'h10});
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
        lit("clr_err", {30'd0, bus.overflow, bus.underflow}, 0);

        // Steady-state wrap-around at occupancy 5.
        for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'h20 + i), 1'b0);
        for (int i = 0; i < 40; i++) begin
            cyc(1'b1, 8'(8'h25 + i), 1'b1);
            if (i == 10) lit("wrap_word", 32'(bus.rdata), 32'(8'h20 + 10));
        end
        lit("wrap_count", {25'd0, bus.overflow, bus.underflow, bus.count}, 32'd5);

        // Both requests while full, then while empty.
        for (int i = 0; i < 11; i++) cyc(1'b1, 8'(8'h60 + i), 1'b0);
        lit("refull", 32'(bus.full), 1);
        cyc(1'b1, 8'hBB, 1'b1);
        lit("full_both", {26'd0, bus.overflow, bus.count}, {26'd0, 1'b1, 5'd15});
        for (int i = 0; i < 15; i++) cyc(1'b0, '0, 1'b1);
        lit("empty_again", 32'(bus.empty), 1);
        cyc(1'b1, 8'hCC, 1'b1);
        lit("empty_both", {26'd0, bus.underflow, bus.count}, {26'd0, 1'b1, 5'd1});
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b1);
        lit("read_cc", 32'(bus.rdata), 32'hCC);

        // Flush at count 7 with both requests.
        for (int i = 0; i < 7; i++) cyc(1'b1, 8'(8'h70 + i), 1'b0);
        lit("pre_flush", 32'(bus.count), 7);
        cyc(1'b1, 8'hDD, 1'b1, 1'b1);
        lit("flush", {24'd0, bus.empty, bus.rvalid, bus.overflow, bus.underflow, bus.count},
            {24'd0, 4'b1000, 5'd0});

        // clr_err concurrent with a new overflow.
        for (int i = 0; i < 17; i++) cyc(1'b1, 8'(8'h80 + i), 1'b0);
        cyc(1'b1, 8'hEE, 1'b0, 1'b0, 1'b1);
        lit("set_beats_clr", 32'(bus.overflow), 1);
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
        lit("clr_after", 32'(bus.overflow), 0);

        // Reset mid-stream at count 9 with a read pending.
        cyc(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 9; i++) cyc(1'b1, 8'(8'h90 + i), 1'b0);
        lit("pre_reset", 32'(bus.count), 9);
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1);
        lit("mid_reset", {20'd0, bus.rdata, bus.rvalid, bus.count, bus.empty},
            {20'd0, 8'd0, 1'b0, 5'd0, 1'b1});
        cyc(1'b1, 8'h5A, 1'b0);
        cyc(1'b0, '0, 1'b1);
        lit("post_reset_rd", {23'd0, bus.rvalid, bus.rdata}, {23'd0, 1'b1, 8'h5A});
        idle();
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sync_fifo_buf.md
# sync_fifo_buf

Single-clock, parametrised FIFO buffer: dual-pointer RAM with registered read port, occupancy count, programmable almost-full/almost-empty thresholds, synchronous flush and sticky overflow/underflow flags. Used wherever producer and consumer share one clock domain (e.g. UART TX/RX byte buffering, register-file command queueing). It is the same-clock counterpart of the async FIFO memory, with added status and error reporting.

## Interface
- DATA_WIDTH, 8, word width in bits
- FIFO_DEPTH, 16, number of entries; power of two, >= 4
- ADDR_WIDTH, 4, log2(FIFO_DEPTH); 2**ADDR_WIDTH must equal FIFO_DEPTH
- AFULL_THR, 14, almost_full asserts when count >= AFULL_THR (1..FIFO_DEPTH)
- AEMPTY_THR, 2, almost_empty asserts when count <= AEMPTY_THR (0..FIFO_DEPTH-1)

- CLK  in  1  single clock; all logic on rising edge
- RST  in  1  synchronous, active-high reset
- flush  in  1  synchronous clear of FIFO contents/state
- clr_err  in  1  clears overflow/underflow
- wr_en  in  1  write request
- wdata  in  DATA_WIDTH  write data
- rd_en  in  1  read request
- rdata  out  DATA_WIDTH  registered read data
- rvalid  out  1  rdata holds a newly read word this cycle
- full  out  1  count == FIFO_DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count >= AFULL_THR
- almost_empty  out  1  count <= AEMPTY_THR
- count  out  ADDR_WIDTH+1  current occupancy, 0..FIFO_DEPTH
- overflow  out  1  sticky: write attempted while full
- underflow  out  1  sticky: read attempted while empty

## Operation
- Pointers wptr/rptr are ADDR_WIDTH+1 bits; low ADDR_WIDTH bits address RAM, MSB is wrap bit; natural binary wrap from FIFO_DEPTH*2-1 to 0.
- count register = wptr - rptr (modulo 2**(ADDR_WIDTH+1)); maintained incrementally: +1 write only, -1 read only, unchanged for both/neither.
- Write accepted iff wr_en && !full (full of current cycle); stores wdata at wptr, wptr+1.
- Read accepted iff rd_en && !empty; rdata <= mem[rptr], rptr+1, rvalid=1 next cycle; otherwise rvalid=0 and rdata holds last value.
- Simultaneous wr_en & rd_en: each judged independently on current flags. When full: read accepted, write rejected. When empty: write accepted, read rejected. Otherwise both accepted, count unchanged.
- Rejected write sets overflow; rejected read sets underflow; both stay set until RST or clr_err. Set wins over clr_err in same cycle.
- full, empty, almost_full, almost_empty decoded from count register only; no combinational path from wr_en/rd_en/wdata to any output.
- flush: wptr, rptr, count <= 0, rvalid <= 0; takes priority over wr_en/rd_en in same cycle (neither accepted, no error flags set); rdata, overflow, underflow unchanged.
- RAM contents are not reset; only pointers, count, outputs.
- Priority: RST > flush > normal operation.

## Timing
- Reset values: rdata 0, rvalid 0, count 0, empty 1, full 0, almost_empty 1, almost_full 0 (AFULL_THR >= 1), overflow 0, underflow 0.
- Write-to-status latency 1 cycle: write at edge N -> count/empty/flags updated after edge N.
- Read latency 1 cycle: rd_en sampled at edge N -> rdata/rvalid valid after edge N, for one cycle.
- Write-to-read: word written at edge N can be read earliest with rd_en at edge N+1 (empty deasserts after N).
- Error flags visible 1 cycle after offending request.
- Sustained throughput: one write and one read per cycle when 0 < count < FIFO_DEPTH.

## Test plan
- Reset then write 0x01..0x10 (16 words) -> full=1, count=16, almost_full asserts after 14th write; 17th write (0xAA) -> overflow=1, count stays 16, data unaffected.
- From full, read 16 words -> rdata 0x01..0x10 in order, rvalid 1 each cycle after rd_en; empty=1 after last; extra rd_en -> underflow=1, rvalid=0, rdata holds 0x10.
- Wrap-around: 40 cycles of continuous wr_en & rd_en with count held at 5 -> output sequence equals input sequence, count constant 5, no error flags.
- Full with wr_en & rd_en together -> read accepted, write rejected, count 15, overflow=1; empty with both -> write accepted, count 1, underflow=1.
- Count 7, assert flush with wr_en & rd_en -> next cycle count 0, empty=1, rvalid=0, no error flags; clr_err clears sticky flags; clr_err concurrent with new overflow -> overflow stays 1.
- Assert RST mid-stream at count 9 with pending rd_en -> next cycle all outputs at reset values; first write afterwards reads back correctly.
